hawk_tol_ht_tracker: RTL and testbench
======================================

# hawk_tol_ht_tracker

Parametrised head/tail tracker for the HAWK Table-of-Lists: keeps head and tail entry IDs for NUM_LISTS doubly-linked lists (free, uncompressed, and any number of irregular free lists), generalising the fixed-size ToL head/tail record to N lists. It sits between the compression unit (command source) and the page-write manager: push and pop commands update head/tail state locally, and the DRAM-resident ListEntry prev/next fields are updated through a link-write request handshake. Entry ID 0 is NULL and is never a valid list member.

## Interface
- NUM_LISTS, 3, number of tracked lists (index 0 free, 1 uncompressed, 2..N-1 irregular free lists)
- ID_W, 18, list entry ID width (clogb2(LST_ENTRY_MAX))
- LW, clogb2(NUM_LISTS) (minimum 1), list index width
- CNT_W, ID_W+1, occupancy counter width (used only with HAWK_TOL_CNT_EN)
- LOW_WM, 1, low-watermark threshold (used only with HAWK_TOL_CNT_EN)

- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  reset, synchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_op_i  in  2  0 reserved, 1 PUSH_TAIL, 2 POP_HEAD, 3 INIT
- cmd_list_i  in  LW  target list
- cmd_id_i  in  ID_W  entry pushed (PUSH)
- cmd_next_i  in  ID_W  next field of current head's ListEntry (POP)
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_id_o  out  ID_W  popped entry ID (PUSH/INIT: cmd_id/0)
- rsp_err_o  out  1  command rejected, no state change
- lnk_valid_o  out  1  link-write request
- lnk_ready_i  in  1  page-write manager accepts link write
- lnk_kind_o  out  1  0 PUSH_LINK (tail.next=new, new.prev=tail, new.next=NULL), 1 POP_UNLINK (new.prev=NULL)
- lnk_a_id_o  out  ID_W  PUSH_LINK: old tail; POP_UNLINK: new head
- lnk_b_id_o  out  ID_W  PUSH_LINK: new entry; POP_UNLINK: 0
- head_o, tail_o  out  NUM_LISTS*ID_W  list i at [i*ID_W +: ID_W]
- empty_o  out  NUM_LISTS  head==NULL per list

## Operation
- FSM states IDLE, LINK, RESP. cmd_ready_o=1 only in IDLE.
- IDLE, accept: error check first; on error -> RESP with rsp_err_o=1, no register change.
- Errors: cmd_list_i>=NUM_LISTS; op 0; PUSH with cmd_id_i==0; POP on empty list; POP with head!=tail and cmd_next_i==0.
- PUSH, empty list: head=tail=id -> RESP. Non-empty: lnk latch {0,old tail,id}, tail=id -> LINK.
- POP, head==tail: rsp_id=head, head=tail=0 -> RESP. Otherwise rsp_id=head, head=cmd_next_i, lnk latch {1,cmd_next_i,0} -> LINK.
- INIT: head=tail=0 -> RESP.
- LINK: lnk_valid_o=1, lnk fields stable until lnk_valid&lnk_ready; then RESP. Head/tail already updated on entry.
- RESP: rsp_valid_o=1 one cycle -> IDLE.
- Push of an ID already present is not detected (caller responsibility).

## Timing
- Reset: all heads/tails 0, empty_o all 1, FSM IDLE, cmd_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_id_o=0, lnk_valid_o=0, lnk fields 0, counters 0, low_o all 1.
- Accept at edge T: head_o/tail_o updated at T+1; no-link case rsp_valid_o at T+1, cmd_ready_o high again at T+2 (one command per 2 cycles).
- Link case: lnk_valid_o from T+1; handshake at edge L; rsp_valid_o in cycle L+1; ready at L+2.
- lnk_ready_i asserted before lnk_valid_o has no effect.
- Reset mid-LINK: request dropped, state cleared, no response.
- rsp_id_o/rsp_err_o held valid only while rsp_valid_o=1; 0 otherwise.

## Configuration
- HAWK_TOL_CNT_EN defined: ports cnt_o (NUM_LISTS*CNT_W) and low_o (NUM_LISTS) exist; PUSH increments, POP decrements, INIT zeroes; PUSH with counter all-ones is an error; low_o[i]=cnt<=LOW_WM, registered with counter.
- Undefined: no counters, no cnt_o/low_o ports; behaviour otherwise identical.

## Test plan
- Reset, PUSH list1 id 5 -> head1=tail1=5, no lnk_valid, rsp_valid at T+1, rsp_err=0.
- PUSH list1 id 9 with lnk_ready held low 3 cycles -> lnk {0,5,9} stable 3 cycles, tail1=9, rsp_valid cycle after handshake.
- POP list1 cmd_next=9 -> rsp_id=5, head1=9, lnk {1,9,0}; POP again -> rsp_id=9, list empty, no link; third POP -> rsp_err=1, rsp_id=0.
- PUSH id 0, list index 3 (NUM_LISTS=3), op 0 -> each rsp_err=1, head/tail unchanged.
- rst_ni low during LINK -> lnk_valid 0 next cycle, all lists empty, no rsp_valid.
- With HAWK_TOL_CNT_EN: 3 PUSHes list2 -> cnt2=3, low2=0; 2 POPs -> cnt2=1, low2=1; INIT -> cnt2=0, empty.

Source files
------------

// File: rtl/hawk_tol_ht_tracker.sv
// Head/tail tracker for the HAWK Table-of-Lists: per-list head/tail IDs with a link-write request port.
// Optional per-list occupancy counters and low-watermark flags when HAWK_TOL_CNT_EN is defined.
module hawk_tol_ht_tracker #(
    parameter int NUM_LISTS = 3,
    parameter int ID_W      = 18,
    parameter int LW        = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1,
    parameter int CNT_W     = ID_W + 1,
    parameter int LOW_WM    = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [1:0]                cmd_op_i,
    input  logic [LW-1:0]             cmd_list_i,
    input  logic [ID_W-1:0]           cmd_id_i,
    input  logic [ID_W-1:0]           cmd_next_i,
    output logic                      rsp_valid_o,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic                      rsp_err_o,
    output logic                      lnk_valid_o,
    input  logic                      lnk_ready_i,
    output logic                      lnk_kind_o,
    output logic [ID_W-1:0]           lnk_a_id_o,
    output logic [ID_W-1:0]           lnk_b_id_o,
    output logic [NUM_LISTS*ID_W-1:0] head_o,
    output logic [NUM_LISTS*ID_W-1:0] tail_o,
    output logic [NUM_LISTS-1:0]      empty_o
`ifdef HAWK_TOL_CNT_EN
    ,
    output logic [NUM_LISTS*CNT_W-1:0] cnt_o,
    output logic [NUM_LISTS-1:0]       low_o
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_LINK, ST_RESP} state_t;

    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;

    if (NUM_LISTS < 1 || ID_W < 1 || CNT_W < 1 || LOW_WM < 0) begin : g_param_check
        $error("hawk_tol_ht_tracker: illegal parameter combination");
    end

    state_t          state_reg;
    logic [ID_W-1:0] head_reg [NUM_LISTS];
    logic [ID_W-1:0] tail_reg [NUM_LISTS];
    logic [ID_W-1:0] rsp_id_reg;
    logic            rsp_err_reg;
    logic            lnk_kind_reg;
    logic [ID_W-1:0] lnk_a_reg;
    logic [ID_W-1:0] lnk_b_reg;

    logic            list_ok;
    logic [LW-1:0]   sel;
    logic [ID_W-1:0] cur_head;
    logic [ID_W-1:0] cur_tail;
    logic            cur_empty;
    logic            cur_single;
    logic            cmd_err;

`ifdef HAWK_TOL_CNT_EN
    logic [CNT_W-1:0]     cnt_reg [NUM_LISTS];
    logic [NUM_LISTS-1:0] low_reg;
    logic [CNT_W-1:0]     cnt_cur;
    logic [CNT_W-1:0]     cnt_next;

    always_comb begin
        cnt_cur  = cnt_reg[sel];
        cnt_next = cnt_cur;
        case (cmd_op_i)
            OP_PUSH: cnt_next = cnt_cur + CNT_W'(1);
            OP_POP:  cnt_next = cnt_cur - CNT_W'(1);
            default: cnt_next = '0;
        endcase
    end
`endif

    // Out-of-range list indices are steered to list 0 so the lookup stays in bounds;
    // such commands are rejected anyway.
    always_comb begin
        list_ok    = int'(cmd_list_i) < NUM_LISTS;
        sel        = list_ok ? cmd_list_i : '0;
        cur_head   = head_reg[sel];
        cur_tail   = tail_reg[sel];
        cur_empty  = (cur_head == '0);
        cur_single = (cur_head == cur_tail);
        cmd_err    = !list_ok
                   || (cmd_op_i == 2'd0)
                   || (cmd_op_i == OP_PUSH && cmd_id_i == '0)
                   || (cmd_op_i == OP_POP && cur_empty)
                   || (cmd_op_i == OP_POP && !cur_single && cmd_next_i == '0);
`ifdef HAWK_TOL_CNT_EN
        if (cmd_op_i == OP_PUSH && (&cnt_cur)) begin
            cmd_err = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg    <= ST_IDLE;
            rsp_id_reg   <= '0;
            rsp_err_reg  <= 1'b0;
            lnk_kind_reg <= 1'b0;
            lnk_a_reg    <= '0;
            lnk_b_reg    <= '0;
            for (int i = 0; i < NUM_LISTS; i++) begin
                head_reg[i] <= '0;
                tail_reg[i] <= '0;
            end
`ifdef HAWK_TOL_CNT_EN
            for (int i = 0; i < NUM_LISTS; i++) begin
                cnt_reg[i] <= '0;
            end
            low_reg <= '1;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        rsp_id_reg  <= '0;
                        rsp_err_reg <= cmd_err;
                        state_reg   <= ST_RESP;
                        if (!cmd_err) begin
`ifdef HAWK_TOL_CNT_EN
                            cnt_reg[sel] <= cnt_next;
                            low_reg[sel] <= (cnt_next <= CNT_W'(LOW_WM));
`endif
                            case (cmd_op_i)
                                OP_PUSH: begin
                                    rsp_id_reg    <= cmd_id_i;
                                    tail_reg[sel] <= cmd_id_i;
                                    if (cur_empty) begin
                                        head_reg[sel] <= cmd_id_i;
                                    end else begin
                                        lnk_kind_reg <= 1'b0;
                                        lnk_a_reg    <= cur_tail;
                                        lnk_b_reg    <= cmd_id_i;
                                        state_reg    <= ST_LINK;
                                    end
                                end
                                OP_POP: begin
                                    rsp_id_reg <= cur_head;
                                    if (cur_single) begin
                                        head_reg[sel] <= '0;
                                        tail_reg[sel] <= '0;
                                    end else begin
                                        head_reg[sel] <= cmd_next_i;
                                        lnk_kind_reg  <= 1'b1;
                                        lnk_a_reg     <= cmd_next_i;
                                        lnk_b_reg     <= '0;
                                        state_reg     <= ST_LINK;
                                    end
                                end
                                default: begin
                                    head_reg[sel] <= '0;
                                    tail_reg[sel] <= '0;
                                end
                            endcase
                        end
                    end
                end
                ST_LINK: begin
                    if (lnk_ready_i) begin
                        lnk_kind_reg <= 1'b0;
                        lnk_a_reg    <= '0;
                        lnk_b_reg    <= '0;
                        state_reg    <= ST_RESP;
                    end
                end
                default: begin
                    rsp_id_reg  <= '0;
                    rsp_err_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    // rsp_id_reg is loaded at accept time, so it is masked until the response cycle.
    assign cmd_ready_o = (state_reg == ST_IDLE);
    assign rsp_valid_o = (state_reg == ST_RESP);
    assign rsp_id_o    = rsp_valid_o ? rsp_id_reg : '0;
    assign rsp_err_o   = rsp_valid_o & rsp_err_reg;
    assign lnk_valid_o = (state_reg == ST_LINK);
    assign lnk_kind_o  = lnk_kind_reg;
    assign lnk_a_id_o  = lnk_a_reg;
    assign lnk_b_id_o  = lnk_b_reg;

    for (genvar gi = 0; gi < NUM_LISTS; gi++) begin : g_out
        assign head_o[gi*ID_W +: ID_W] = head_reg[gi];
        assign tail_o[gi*ID_W +: ID_W] = tail_reg[gi];
        assign empty_o[gi]             = (head_reg[gi] == '0);
`ifdef HAWK_TOL_CNT_EN
        assign cnt_o[gi*CNT_W +: CNT_W] = cnt_reg[gi];
`endif
    end

`ifdef HAWK_TOL_CNT_EN
    assign low_o = low_reg;
`endif

endmodule

// File: tb/tb_hawk_tol_ht_tracker.sv
// Bench for hawk_tol_ht_tracker: lists modelled as queues, outputs compared every cycle.
// Counter/watermark ports are exercised when HAWK_TOL_CNT_EN is defined.
module tb_hawk_tol_ht_tracker;

    localparam int NL    = 3;
    localparam int IW    = 18;
    localparam int LW    = 2;
    localparam int CW    = IW + 1;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [1:0]        cmd_op_i;
    logic [LW-1:0]     cmd_list_i;
    logic [IW-1:0]     cmd_id_i;
    logic [IW-1:0]     cmd_next_i;
    logic              rsp_valid_o;
    logic [IW-1:0]     rsp_id_o;
    logic              rsp_err_o;
    logic              lnk_valid_o;
    logic              lnk_ready_i;
    logic              lnk_kind_o;
    logic [IW-1:0]     lnk_a_id_o;
    logic [IW-1:0]     lnk_b_id_o;
    logic [NL*IW-1:0]  head_o;
    logic [NL*IW-1:0]  tail_o;
    logic [NL-1:0]     empty_o;
`ifdef HAWK_TOL_CNT_EN
    logic [NL*CW-1:0]  cnt_o;
    logic [NL-1:0]     low_o;
`endif

    hawk_tol_ht_tracker #(.NUM_LISTS(NL), .ID_W(IW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_list_i  (cmd_list_i),
        .cmd_id_i    (cmd_id_i),
        .cmd_next_i  (cmd_next_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_err_o   (rsp_err_o),
        .lnk_valid_o (lnk_valid_o),
        .lnk_ready_i (lnk_ready_i),
        .lnk_kind_o  (lnk_kind_o),
        .lnk_a_id_o  (lnk_a_id_o),
        .lnk_b_id_o  (lnk_b_id_o),
        .head_o      (head_o),
        .tail_o      (tail_o),
        .empty_o     (empty_o)
`ifdef HAWK_TOL_CNT_EN
        ,
        .cnt_o       (cnt_o),
        .low_o       (low_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Model: each list is the ordered sequence of its members, head first.
    int q [NL][$];
    bit exp_ready, exp_rsp_valid, exp_rsp_err, exp_lnk_valid, exp_lnk_kind;
    int exp_rsp_id, exp_lnk_a, exp_lnk_b;
    bit chk_en = 1'b0;
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic int mhead(input int i);
        return (q[i].size() > 0) ? q[i][0] : 0;
    endfunction

    function automatic int mtail(input int i);
        return (q[i].size() > 0) ? q[i][q[i].size()-1] : 0;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            for (int i = 0; i < NL; i++) begin
                chk($sformatf("head%0d", i), head_o[i*IW +: IW], mhead(i));
                chk($sformatf("tail%0d", i), tail_o[i*IW +: IW], mtail(i));
                chk($sformatf("empty%0d", i), empty_o[i], q[i].size() == 0);
`ifdef HAWK_TOL_CNT_EN
                chk($sformatf("cnt%0d", i), cnt_o[i*CW +: CW], q[i].size());
                chk($sformatf("low%0d", i), low_o[i], q[i].size() <= 1);
`endif
            end
            chk("cmd_ready", cmd_ready_o, exp_ready);
            chk("rsp_valid", rsp_valid_o, exp_rsp_valid);
            chk("rsp_id", rsp_id_o, exp_rsp_id);
            chk("rsp_err", rsp_err_o, exp_rsp_err);
            chk("lnk_valid", lnk_valid_o, exp_lnk_valid);
            chk("lnk_kind", lnk_kind_o, exp_lnk_kind);
            chk("lnk_a", lnk_a_id_o, exp_lnk_a);
            chk("lnk_b", lnk_b_id_o, exp_lnk_b);
        end
    end

    // Issue one command; called and returns at posedge+1. abort pulls reset during LINK.
    task automatic cmd(input int op, input int lst, input int id, input int nxt,
                       input int lwait, input bit pre_rdy, input bit abort);
        bit err, lnk, kind;
        int rid, la, lb;
        err = (lst >= NL) || (op == 0) || (op == 1 && id == 0)
           || (op == 2 && lst < NL && q[lst].size() == 0)
           || (op == 2 && lst < NL && q[lst].size() > 1 && nxt == 0);
        lnk = 1'b0; kind = 1'b0; rid = 0; la = 0; lb = 0;
        if (!err) begin
            case (op)
                1: begin rid = id; lnk = q[lst].size() > 0; la = mtail(lst); lb = id; end
                2: begin rid = mhead(lst); lnk = q[lst].size() > 1; kind = 1'b1; la = nxt; end
                default: ;
            endcase
        end
        $display("cmd op=%0d list=%0d id=%0d next=%0d -> exp rsp_id=%0d err=%0d link=%0d",
                 op, lst, id, nxt, rid, err, lnk);
        cmd_valid_i = 1'b1; cmd_op_i = 2'(op); cmd_list_i = LW'(lst);
        cmd_id_i = IW'(id); cmd_next_i = IW'(nxt); lnk_ready_i = pre_rdy;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_list_i = '0; cmd_id_i = '0; cmd_next_i = '0;
        lnk_ready_i = 1'b0;
        if (!err) begin
            case (op)
                1: q[lst].push_back(id);
                2: void'(q[lst].pop_front());
                default: q[lst].delete();
            endcase
        end
        exp_ready = 1'b0;
        if (lnk) begin
            exp_lnk_valid = 1'b1; exp_lnk_kind = kind; exp_lnk_a = la; exp_lnk_b = lb;
            if (abort) begin
                rst_ni = 1'b0;
                @(posedge clk_i); #1;
                for (int i = 0; i < NL; i++) q[i].delete();
                exp_lnk_valid = 1'b0; exp_lnk_kind = 1'b0; exp_lnk_a = 0; exp_lnk_b = 0;
                exp_ready = 1'b1;
                rst_ni = 1'b1;
                @(posedge clk_i); #1;
                return;
            end
            repeat (lwait) begin
                @(posedge clk_i); #1;
            end
            lnk_ready_i = 1'b1;
            @(posedge clk_i); #1;
            lnk_ready_i = 1'b0;
            exp_lnk_valid = 1'b0; exp_lnk_kind = 1'b0; exp_lnk_a = 0; exp_lnk_b = 0;
        end
        exp_rsp_valid = 1'b1; exp_rsp_id = rid; exp_rsp_err = err;
        @(posedge clk_i); #1;
        exp_rsp_valid = 1'b0; exp_rsp_id = 0; exp_rsp_err = 1'b0; exp_ready = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_list_i = '0;
        cmd_id_i = '0; cmd_next_i = '0; lnk_ready_i = 1'b0;
        exp_ready = 1'b1; exp_rsp_valid = 1'b0; exp_rsp_err = 1'b0; exp_rsp_id = 0;
        exp_lnk_valid = 1'b0; exp_lnk_kind = 1'b0; exp_lnk_a = 0; exp_lnk_b = 0;
        repeat (2) @(posedge clk_i);
        #1 chk_en = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_empty_lit", empty_o, 3'b111);
        rst_ni = 1'b1;

        // Basic push/link/pop sequence on list 1
        cmd(1, 1, 5, 0, 0, 0, 0);
        chk("head1_lit", head_o[IW +: IW], 5);
        chk("tail1_lit", tail_o[IW +: IW], 5);
        cmd(1, 1, 9, 0, 3, 0, 0);
        chk("tail1_after_link_lit", tail_o[IW +: IW], 9);
        cmd(2, 1, 0, 9, 1, 0, 0);
        chk("head1_after_pop_lit", head_o[IW +: IW], 9);
        cmd(2, 1, 0, 0, 0, 0, 0);
        cmd(2, 1, 0, 0, 0, 0, 0);
        chk("empty1_lit", empty_o[1], 1);

        // Rejected commands leave list 0 alone
        cmd(1, 0, 11, 0, 0, 0, 0);
        cmd(1, 0, 0, 0, 0, 0, 0);
        cmd(1, 3, 7, 0, 0, 0, 0);
        cmd(0, 0, 7, 0, 0, 0, 0);
        chk("head0_after_errs_lit", head_o[0 +: IW], 11);

        // Early lnk_ready, then two-entry pops on list 0
        cmd(1, 0, 12, 0, 2, 1, 0);
        cmd(2, 0, 0, 12, 0, 0, 0);
        cmd(2, 0, 0, 0, 0, 0, 0);

        // Irregular list: counts, watermark, INIT
        cmd(1, 2, 21, 0, 0, 0, 0);
        cmd(1, 2, 22, 0, 1, 0, 0);
        cmd(1, 2, 23, 0, 0, 0, 0);
`ifdef HAWK_TOL_CNT_EN
        chk("cnt2_three_lit", cnt_o[2*CW +: CW], 3);
        chk("low2_three_lit", low_o[2], 0);
`endif
        cmd(2, 2, 0, 22, 0, 0, 0);
        cmd(2, 2, 0, 23, 2, 0, 0);
`ifdef HAWK_TOL_CNT_EN
        chk("cnt2_one_lit", cnt_o[2*CW +: CW], 1);
        chk("low2_one_lit", low_o[2], 1);
`endif
        cmd(3, 2, 0, 0, 0, 0, 0);
        chk("empty2_init_lit", empty_o[2], 1);

        // POP with head!=tail and NULL next is rejected
        cmd(1, 0, 31, 0, 0, 0, 0);
        cmd(1, 0, 32, 0, 0, 0, 0);
        cmd(2, 0, 0, 0, 0, 0, 0);
        chk("head0_badpop_lit", head_o[0 +: IW], 31);
        cmd(3, 0, 0, 0, 0, 0, 0);

        // Reset while a link write is pending
        cmd(1, 1, 40, 0, 0, 0, 0);
        cmd(1, 1, 41, 0, 0, 0, 1);
        chk("empty_after_abort_lit", empty_o, 3'b111);
        cmd(1, 2, 50, 0, 0, 0, 0);
        chk("head2_resume_lit", head_o[2*IW +: IW], 50);

        @(negedge clk_i);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
